// File: rtl/byte_msg_assembler.sv
// byte_msg_assembler: frames a valid-qualified byte stream into 3-byte messages.
// A message opens on a byte with bit[3] set, collects two more bytes and is
// published on out_bytes with a one-cycle done pulse. A partial message left
// idle for TIMEOUT consecutive cycles is abandoned and counted as a drop.
module byte_msg_assembler #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [23:0] out_bytes,
  output logic        done,
  output logic        drop,
  output logic [7:0]  drop_count
);

  // A zero TIMEOUT would give a zero-width counter, so keep at least one bit.
  localparam int unsigned CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned IDLE_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    SEARCH,
    B1,
    B2,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [7:0]    byte1, byte1_next;
  logic [7:0]    byte2, byte2_next;
  logic [CW-1:0] idle_cnt, idle_next;
  logic [23:0]   out_next;
  logic          done_next;
  logic          drop_next;
  logic [7:0]    drop_count_next;
  logic          idle_expired;

  // An idle cycle inside a partial message that completes the tolerated gap.
  assign idle_expired = (TIMEOUT != 0) && !in_valid && (idle_cnt == CW'(IDLE_LAST));

  // Registers every piece of state and every output so nothing combinational
  // reaches the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      byte1      <= 8'd0;
      byte2      <= 8'd0;
      idle_cnt   <= '0;
      out_bytes  <= 24'd0;
      done       <= 1'b0;
      drop       <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_next;
      byte1      <= byte1_next;
      byte2      <= byte2_next;
      idle_cnt   <= idle_next;
      out_bytes  <= out_next;
      done       <= done_next;
      drop       <= drop_next;
      drop_count <= drop_count_next;
    end
  end

  // Framing decisions; only accepted bytes move the message forward, and idle
  // cycles in B1/B2 run the abort timer.
  always_comb begin
    state_next      = state;
    byte1_next      = byte1;
    byte2_next      = byte2;
    idle_next       = idle_cnt;
    out_next        = out_bytes;
    done_next       = 1'b0;
    drop_next       = 1'b0;
    drop_count_next = drop_count;

    case (state)
      SEARCH: begin
        if (in_valid && in_byte[3]) begin
          state_next = B1;
          byte1_next = in_byte;
          idle_next  = '0;
        end
      end

      B1, B2: begin
        if (in_valid) begin
          idle_next = '0;
          if (state == B1) begin
            state_next = B2;
            byte2_next = in_byte;
          end else begin
            state_next = DONE;
            out_next   = {byte1, byte2, in_byte};
            done_next  = 1'b1;
          end
        end else if (idle_expired) begin
          state_next = SEARCH;
          idle_next  = '0;
          drop_next  = 1'b1;
          if (drop_count != 8'hFF) begin
            drop_count_next = drop_count + 8'd1;
          end
        end else if (TIMEOUT != 0) begin
          idle_next = idle_cnt + 1'b1;
        end
      end

      DONE: begin
        if (in_valid && in_byte[3]) begin
          state_next = B1;
          byte1_next = in_byte;
          idle_next  = '0;
        end else begin
          state_next = SEARCH;
        end
      end

      default: begin
        state_next = SEARCH;
      end
    endcase
  end

endmodule

// File: tb/tb_byte_msg_assembler.sv
// Testbench for byte_msg_assembler: directed scenarios followed by random
// traffic, every cycle compared against a queue-based message model.
module tb_byte_msg_assembler;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic [23:0] out_bytes;
  logic        done;
  logic        drop;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: bytes of the message being collected so far.
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [23:0] m_out;
  logic        m_done;
  logic        m_drop;
  int          m_cnt;

  byte_msg_assembler #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .out_bytes  (out_bytes),
    .done       (done),
    .drop       (drop),
    .drop_count (drop_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advances the model by one clock edge given the inputs seen at that edge.
  function automatic void modelStep(input logic rst, input logic v, input logic [7:0] b);
    m_done = 1'b0;
    m_drop = 1'b0;
    if (rst) begin
      m_q.delete();
      m_idle = 0;
      m_out  = 24'd0;
      m_cnt  = 0;
    end else if (v) begin
      m_idle = 0;
      if (m_q.size() != 0 || b[3]) m_q.push_back(b);
      if (m_q.size() == 3) begin
        m_out  = {m_q[0], m_q[1], m_q[2]};
        m_done = 1'b1;
        m_q.delete();
      end
    end else if (m_q.size() != 0 && TO != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_drop = 1'b1;
        m_q.delete();
        m_idle = 0;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endfunction

  // Single comparison point with failure accounting.
  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge and compares
  // all outputs shortly after it.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] b);
    reset    = rst;
    in_valid = v;
    in_byte  = b;
    @(posedge clk);
    modelStep(rst, v, b);
    #1;
    checkOutput("done",       {23'd0, done},       {23'd0, m_done});
    checkOutput("drop",       {23'd0, drop},       {23'd0, m_drop});
    checkOutput("out_bytes",  out_bytes,           m_out);
    checkOutput("drop_count", {16'd0, drop_count}, 24'(m_cnt));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] rb;
    int         done_seen;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'd0;
    m_q.delete();
    m_idle = 0;
    m_out  = 24'd0;
    m_done = 1'b0;
    m_drop = 1'b0;
    m_cnt  = 0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'h08);
    checkOutput("reset_out", out_bytes, 24'd0);

    $display("[TB] single message");
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b0, 1'b1, 8'h22);
    checkOutput("msg1_done", {23'd0, done}, 24'd1);
    checkOutput("msg1_out", out_bytes, 24'h081122);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("msg1_done_low", {23'd0, done}, 24'd0);

    $display("[TB] leading bytes discarded");
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h07);
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 8'hBB);
    checkOutput("msg2_out", out_bytes, 24'h08AABB);
    idleCycles(2);

    $display("[TB] back-to-back messages");
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h02);
    checkOutput("b2b_first", out_bytes, 24'h080102);
    applyStimulus(1'b0, 1'b1, 8'h0F);
    applyStimulus(1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b1, 8'h04);
    checkOutput("b2b_second", out_bytes, 24'h0F0304);
    checkOutput("b2b_done", {23'd0, done}, 24'd1);
    idleCycles(1);

    $display("[TB] timeout abort");
    applyStimulus(1'b0, 1'b1, 8'h08);
    idleCycles(TO - 1);
    checkOutput("pre_abort_drop", {23'd0, drop}, 24'd0);
    idleCycles(1);
    checkOutput("abort_drop", {23'd0, drop}, 24'd1);
    checkOutput("abort_count", {16'd0, drop_count}, 24'd1);
    checkOutput("abort_out_held", out_bytes, 24'h0F0304);
    idleCycles(1);

    $display("[TB] byte on the timeout edge");
    applyStimulus(1'b0, 1'b1, 8'h08);
    idleCycles(TO - 1);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("edge_no_drop", {23'd0, drop}, 24'd0);
    idleCycles(TO - 1);
    applyStimulus(1'b0, 1'b1, 8'h66);
    checkOutput("edge_out", out_bytes, 24'h085566);
    checkOutput("edge_count", {16'd0, drop_count}, 24'd1);

    $display("[TB] drop_count saturation");
    for (int k = 0; k < 260; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h08 | 8'($urandom));
      idleCycles(TO);
    end
    checkOutput("sat_count", {16'd0, drop_count}, 24'd255);

    $display("[TB] reset mid-message");
    applyStimulus(1'b0, 1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h11);
    applyStimulus(1'b1, 1'b1, 8'h22);
    checkOutput("rst_count", {16'd0, drop_count}, 24'd0);
    checkOutput("rst_out", out_bytes, 24'd0);
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, 8'h22);
    done_seen += int'(done);
    applyStimulus(1'b0, 1'b1, 8'h08);
    done_seen += int'(done);
    applyStimulus(1'b0, 1'b1, 8'h33);
    done_seen += int'(done);
    applyStimulus(1'b0, 1'b1, 8'h44);
    done_seen += int'(done);
    checkOutput("rst_next_out", out_bytes, 24'h083344);
    checkOutput("rst_done_pulses", 24'(done_seen), 24'd1);

    $display("[TB] random traffic");
    for (int k = 0; k < 1500; k++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        idleCycles(TO - 2 + int'($urandom_range(0, 4)));
      end else if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1'b1, $urandom_range(0, 1) == 1, rb);
      end else begin
        applyStimulus(1'b0, $urandom_range(0, 3) != 0, rb);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
